// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    // Receiver FSM: wait for start bit, shift data/parity/stop, evaluate.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Full frame on the wire: start, 8 data, parity, stop.
    localparam int unsigned FRAME_LEN      = 11;
    localparam int unsigned FILTER_LEN_DEF = 8;
    localparam int unsigned TIMEOUT_DEF    = 7500;

    // Bits shifted after the start bit (data, parity, stop).
    localparam int unsigned DPS_BITS  = FRAME_LEN - 1;
    localparam int unsigned BIT_CNT_W = 4;

    // Shift register contents once a frame has been fully shifted in.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } frame_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 clock, debounces it and flags falling edges.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c,
    output logic fall_edge,
    output logic filt_c
);

    logic                  c_meta;
    logic                  c_sync;
    logic [FILTER_LEN-1:0] hist;
    logic [FILTER_LEN-1:0] hist_next;
    logic                  filt_next;
    logic                  filt_d;

    // Filtered level changes only when the whole history agrees.
    always_comb begin
        hist_next = {hist[FILTER_LEN-2:0], c_sync};
        filt_next = filt_c;
        if (&hist_next) begin
            filt_next = 1'b1;
        end else if (~|hist_next) begin
            filt_next = 1'b0;
        end
    end

    // Sync flops, history, filtered level and edge pulse; reset to bus-idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_meta    <= 1'b1;
            c_sync    <= 1'b1;
            hist      <= '1;
            filt_c    <= 1'b1;
            filt_d    <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            c_meta    <= ps2c;
            c_sync    <= c_meta;
            hist      <= hist_next;
            filt_c    <= filt_next;
            filt_d    <= filt_c;
            fall_edge <= filt_d & ~filt_c;
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with parity, stop-bit and timeout checks.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int unsigned          TMO_W        = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]     TMO_LAST     = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]     TMO_MAX      = '1;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LOAD = BIT_CNT_W'(DPS_BITS - 1);

    logic                 fall_edge;
    logic                 filt_c;
    logic                 edge_ok;
    logic                 d_meta;
    logic                 d_sync;

    state_t               state_q;
    state_t               state_d;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic [BIT_CNT_W-1:0] cnt_d;
    logic [DPS_BITS-1:0]  sr_q;
    logic [DPS_BITS-1:0]  sr_d;
    logic [DPS_BITS-1:0]  sr_shift;
    frame_t               frm;
    logic [TMO_W-1:0]     tmo_q;
    logic [TMO_W-1:0]     tmo_d;
    logic [7:0]           dout_d;
    logic                 done_d;
    logic                 perr_d;
    logic                 ferr_d;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk       (clk),
        .rst       (rst),
        .ps2c      (ps2c),
        .fall_edge (fall_edge),
        .filt_c    (filt_c)
    );

    // An edge is only acted on while the filtered clock is still low.
    assign edge_ok = fall_edge & ~filt_c;

    // Two-flop synchronizer for the data line.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    // Next state, counters and the frame verdict issued on entry to LOAD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        tmo_d    = tmo_q;
        dout_d   = dout;
        done_d   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        sr_shift = {d_sync, sr_q[DPS_BITS-1:1]};
        frm      = frame_t'(sr_shift);

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (edge_ok && rx_en && !d_sync) begin
                    state_d = DPS;
                    cnt_d   = BIT_CNT_LOAD;
                end
            end
            DPS: begin
                if (edge_ok) begin
                    tmo_d = '0;
                    sr_d  = sr_shift;
                    if (cnt_q == '0) begin
                        state_d = LOAD;
                        if (!frm.stop) begin
                            ferr_d = 1'b1;
                        end else if (!(^{frm.data, frm.parity})) begin
                            perr_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            dout_d = frm.data;
                        end
                    end else begin
                        cnt_d = cnt_q - BIT_CNT_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Line stalled mid-frame: drop the partial byte.
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                    sr_d    = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, datapath and registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            tmo_q        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            tmo_q        <= tmo_d;
            dout         <= dout_d;
            rx_done_tick <= done_d;
            err_parity   <= perr_d;
            err_frame    <= ferr_d;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are driven bit by bit, expected events queued.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int unsigned FL   = 8;
    localparam int unsigned TMO  = 300;
    localparam int unsigned HALF = 40;

    localparam int K_DONE = 0;
    localparam int K_PAR  = 1;
    localparam int K_FRM  = 2;

    typedef struct {
        int         kind;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2d;
    logic       ps2c;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       err_parity;
    logic       err_frame;

    exp_t        sb[$];
    exp_t        mon_e;
    int          mon_kind;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fe_cnt = 0;
    int unsigned cyc = 0;
    int unsigned last_evt_cyc = 0;
    int unsigned last_fall_cyc = 0;
    logic [7:0]  model_dout;

    ps2_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .err_parity   (err_parity),
        .err_frame    (err_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every output pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (rx_done_tick || err_parity || err_frame) begin
            last_evt_cyc = cyc;
            check("onehot", 32'($countones({rx_done_tick, err_parity, err_frame})), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, rx_done_tick, err_parity, err_frame}, 32'd0);
            end else begin
                mon_e    = sb.pop_front();
                mon_kind = rx_done_tick ? K_DONE : (err_parity ? K_PAR : K_FRM);
                check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                check("event_dout", {24'd0, dout}, {24'd0, mon_e.d});
            end
        end
    end

    // Count filtered falling edges for the glitch test.
    always @(negedge clk) begin
        if (dut.u_filt.fall_edge) fe_cnt++;
    end

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        repeat (HALF) @(negedge clk);
        ps2c          = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
    endtask

    // Drive the first nbits of a frame; rx_en drops after bit drop_at.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int drop_at);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i]);
            if (i == drop_at) rx_en = 1'b0;
        end
        ps2d = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        model_dout = d;
        push(K_DONE, d);
        send_frame(d, ~^d, 1'b1, 11, 99);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst        = 1'b1;
        ps2c       = 1'b1;
        ps2d       = 1'b1;
        rx_en      = 1'b1;
        model_dout = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_pulses", {29'd0, rx_done_tick, err_parity, err_frame}, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_edges", 32'(fe_cnt), 32'd0);

        // Single good frame and its latency from the raw stop-bit fall.
        good_frame(8'h1C);
        wait_drain(100);
        check("lat_done", last_evt_cyc - last_fall_cyc, FL + 4);

        // Back-to-back frames.
        good_frame(8'hF0);
        good_frame(8'h1C);
        wait_drain(100);

        // Parity error keeps dout.
        push(K_PAR, model_dout);
        send_frame(8'h1C, 1'b1, 1'b1, 11, 99);
        wait_drain(100);

        // Bad stop bit.
        push(K_FRM, model_dout);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 99);
        wait_drain(100);

        // Short low glitch on an idle bus.
        repeat (50) @(negedge clk);
        begin
            int fe0;
            fe0  = fe_cnt;
            ps2c = 1'b0;
            repeat (3) @(negedge clk);
            ps2c = 1'b1;
            repeat (30) @(negedge clk);
            check("glitch_edges", 32'(fe_cnt - fe0), 32'd0);
            check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        end

        // Clock stops after 5 bits, then a good frame recovers.
        push(K_FRM, model_dout);
        send_frame(8'h55, 1'b1, 1'b1, 5, 99);
        wait_drain(TMO + 200);
        check("lat_tmo", last_evt_cyc - last_fall_cyc, FL + 4 + TMO);
        good_frame(8'h29);
        wait_drain(100);

        // rx_en low at the start bit: frame ignored.
        rx_en = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 99);
        repeat (50) @(negedge clk);
        rx_en = 1'b1;
        check("rxen0_state", 32'(dut.state_q), 32'(IDLE));
        check("rxen0_dout", {24'd0, dout}, {24'd0, model_dout});

        // rx_en dropped mid-frame does not abort it.
        model_dout = 8'h5A;
        push(K_DONE, 8'h5A);
        send_frame(8'h5A, ~^8'h5A, 1'b1, 11, 2);
        wait_drain(100);
        rx_en = 1'b1;

        // Reset at bit 6 discards the frame with no pulses.
        send_frame(8'h1C, 1'b0, 1'b1, 7, 99);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        model_dout = 8'h00;
        repeat (TMO + 100) @(negedge clk);
        check("rst_mid_dout", {24'd0, dout}, {24'd0, model_dout});
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
